// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: the forward key schedule runs first, then one
// decryption round per cycle while the round key is stepped back alongside it.
module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ARK0, ROUND} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] dout_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Exact inverse of xtime over the ten rcon values used by AES-128.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        if (b == 8'h1b) return 8'h80;
        return {1'b0, b[7:1]} ^ (b[0] ? 8'h8d : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 via square-and-multiply; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(gf_mul(t, t), a);
        end
        return gf_mul(t, t);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] u;
        u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(u);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    logic [31:0]  w0, w1, w2, w3, p1, p2, p3;
    logic [31:0]  sub_in, rot_word, sub_word, temp;
    logic [31:0]  n0, n1, n2, n3, p0;
    logic [127:0] rk_fwd, rk_inv;

    assign {w0, w1, w2, w3} = rk_q;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // Forward and inverse schedules never run in the same cycle, so they share one SubWord.
    assign sub_in   = (fsm_q == KEYEXP) ? w3 : p3;
    assign rot_word = {sub_in[23:0], sub_in[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_subword
        assign sub_word[31-8*k -: 8] = sbox_fwd(rot_word[31-8*k -: 8]);
    end

    assign temp   = sub_word ^ {rcon_q, 24'h0};
    assign n0     = w0 ^ temp;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;
    assign p0     = w0 ^ temp;
    assign rk_fwd = {n0, n1, n2, n3};
    assign rk_inv = {p0, p1, p2, p3};

    logic [127:0] isb, ark, imc;

    // InvShiftRows is pure wiring folded into the inverse S-box inputs.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign isb[127-8*DST -: 8] = sbox_inv(blk_q[127-8*SRC -: 8]);
        end
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign ark  = isb ^ rk_q;
    assign busy = (fsm_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            rk_q   <= '0;
            rcon_q <= '0;
            cnt_q  <= '0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            rk_q   <= rk_d;
            rcon_q <= rcon_d;
            cnt_q  <= cnt_d;
            dout   <= dout_d;
            done   <= done_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rk_d   = rk_q;
        rcon_d = rcon_q;
        cnt_d  = cnt_q;
        dout_d = dout;
        done_d = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    blk_d  = din;
                    rk_d   = key;
                    rcon_d = 8'h01;
                    cnt_d  = 4'd0;
                    fsm_d  = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d  = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                // rcon stays at 36 after the last step, ready for the first step back.
                if (cnt_q == 4'd9) begin
                    fsm_d = ARK0;
                end else begin
                    rcon_d = xtime(rcon_q);
                end
            end
            ARK0: begin
                blk_d  = blk_q ^ rk_q;
                rk_d   = rk_inv;
                rcon_d = inv_xtime(rcon_q);
                cnt_d  = 4'd9;
                fsm_d  = ROUND;
            end
            ROUND: begin
                if (cnt_q != 4'd0) begin
                    blk_d  = imc;
                    rk_d   = rk_inv;
                    rcon_d = inv_xtime(rcon_q);
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    blk_d  = ark;
                    dout_d = ark;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter using FIPS-197 vectors: expected plaintexts
// are queued at the start edge and checked with their latency when done pulses.
module tb_aes128_decrypt_iter;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KZ  = 128'h0;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] PZ  = 128'h0;
    localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] din;
    logic         busy;
    logic         done;
    logic [127:0] dout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int spurious = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic [127:0] exp_q[$];
    int           start_q[$];
    logic [127:0] mon_exp;
    int           mon_start;
    int           base_cnt;

    aes128_decrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .key   (key),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driven at a negedge while the DUT is idle; returns on the negedge after the start edge.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c,
                                 input logic [127:0] p, input logic hold);
        key   = k;
        din   = c;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(p);
        start_q.push_back(cyc);
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 128'(done), 128'(1'b1));
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() > 0) begin
                mon_exp   = exp_q.pop_front();
                mon_start = start_q.pop_front();
                checkOutput("dout", dout, mon_exp);
                checkOutput("latency", 128'(cyc - mon_start), 128'd21);
                checkOutput("busy_at_done", 128'(busy), 128'd0);
            end else begin
                spurious++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key   = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        checkOutput("reset_dout", dout, 128'd0);
        rst_n = 1'b1;

        $display("[TB] C.1 vector with per-cycle busy check");
        applyStimulus(K1, C1, P1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("busy_done_c%0d", i), 128'({busy, done}), 128'(2'b10));
            if (i == 10) checkOutput("rk10", dut.rk_q, RK10);
        end
        waitDone("done_c1", 5);

        $display("[TB] C.1 with ignored restarts, then zero vector");
        applyStimulus(K1, C1, P1, 1'b0);
        repeat (4) @(negedge clk);
        key = KZ; din = CZ; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        key = KB; din = CB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("done_restart", 30);
        applyStimulus(KZ, CZ, PZ, 1'b0);
        waitDone("done_zero", 30);

        $display("[TB] App. B vector");
        applyStimulus(KB, CB, PB, 1'b0);
        waitDone("done_appb", 30);

        $display("[TB] reset mid-block");
        applyStimulus(K1, C1, P1, 1'b0);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_done", 128'(done), 128'd0);
        checkOutput("rst_dout", dout, 128'd0);
        exp_q.delete();
        start_q.delete();
        base_cnt = done_cnt;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("no_done_after_reset", 128'(done_cnt - base_cnt), 128'd0);
        applyStimulus(K1, C1, P1, 1'b0);
        waitDone("done_after_reset", 30);

        $display("[TB] back-to-back with start held high");
        applyStimulus(KB, CB, PB, 1'b1);
        key = K1;
        din = C1;
        repeat (22) @(negedge clk);
        exp_q.push_back(P1);
        start_q.push_back(cyc);
        start = 1'b0;
        checkOutput("b2b_dout_hold", dout, PB);
        repeat (10) @(negedge clk);
        checkOutput("b2b_dout_hold2", dout, PB);
        waitDone("done_b2b", 30);
        checkOutput("b2b_gap", 128'(last_done_cyc - prev_done_cyc), 128'd22);

        repeat (3) @(negedge clk);
        checkOutput("spurious_done", 128'(spurious), 128'd0);
        checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative, round-per-cycle AES-128 inverse cipher (FIPS-197) that recovers plaintext from a 128-bit ciphertext block under a 128-bit key. It is the receive-side counterpart to the encryption datapath. The block sits behind the chip's pin-level plumbing: a 128-bit ciphertext and key go in, and a start/done handshake brackets each block. It replaces a fully unrolled combinational decryptor with about 21 cycles of latency and one shared round datapath.

## Interface

- No parameters; key size is fixed at 128 bits, 10 rounds.
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- key  input  128  cipher key, FIPS byte order, byte 0 in [127:120]; sampled with start
- din  input  128  ciphertext, same byte order; sampled with start
- busy  output  1  high while a block is in flight
- done  output  1  one-cycle pulse when dout is updated
- dout  output  128  plaintext; holds its last value until the next completion

## Operation

- States: IDLE, KEYEXP, ARK0, ROUND.
- IDLE:
  - On start=1, latch din into the state register and key into the round-key register.
  - Set rcon=8'h01 and cnt=0, then go to KEYEXP.
  - start=0 keeps the block in IDLE.
- KEYEXP runs 10 cycles and advances the forward key schedule once per cycle.
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - rcon advances by xtime each cycle (01,02,…,80,1b,36).
  - After 10 steps the round-key register holds rk10 and rcon=8'h36. Go to ARK0.
- ARK0 takes 1 cycle.
  - state ^= rk10.
  - Step the round key back to rk9 using the inverse schedule (below) with rcon=36.
  - Step rcon back to 1b. Set cnt=9 and go to ROUND.
- Inverse schedule, from rk_r to rk_{r-1}: p3=k3^k2; p2=k2^k1; p1=k1^k0; p0=k0^SubWord(RotWord(p3))^{rcon_r,24'h0}.
- rcon step-back is the inverse of xtime: 1b→80; otherwise a right shift, with 0x8d folded in when bit0 is set.
- ROUND takes 1 cycle per round.
  - cnt 9..1: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_cnt)), then step the round key back.
  - cnt=0: state = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0). dout takes this result, done pulses, and the state returns to IDLE.
- S-boxes:
  - Forward SubWord needs 4 instances; inverse SubBytes needs 16.
  - Both are built on a shared GF(2^8) inverse, modulus x^8+x^4+x^3+x+1.
  - Forward S-box applies the affine transform after the inverse; inverse S-box applies the inverse affine transform before it.
  - No 256-entry lookup tables.
- start while busy is ignored; there is no queueing.
- key and din may change after the start cycle without effect.
- Reset asserted at any time, including mid-operation:
  - Go to IDLE immediately; busy=0, done=0, dout=0.
  - Internal state, round-key register, rcon and cnt all clear.
  - Any in-flight block is discarded, and no done follows.

## Timing

- Reset values: busy=0, done=0, dout=128'h0.
- start sampled high at rising edge N:
  - busy=1 from N through N+20.
  - KEYEXP occupies edges N+1..N+10, ARK0 edge N+11, ROUND edges N+12..N+21.
  - At edge N+21: dout updates, done=1 for that single cycle, busy=0.
- Latency is 21 cycles from the start edge to done, and the block accepts a new start at edge N+22 at the earliest.
- start held high continuously yields one block every 22 cycles, with din/key re-sampled each time.
- done is never high while busy is high.
- dout changes only on a done cycle or on reset.

## Test plan

- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a → dout=00112233445566778899aabbccddeeff. done exactly 21 cycles after start; busy high for cycles 1–20.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 → dout=3243f6a8885a308d313198a2e0370734.
- Zero vector: key=0, din=66e94bd4ef8a2c3b884cfa59ca342b2e → dout=0. Internal check: the round key after KEYEXP for the C.1 key is 13111d7fe3944a17f307a78b4d2b30c5.
- start re-pulsed with a different din at cycles 5 and 15 of an in-flight C.1 block → ignored. The result is still the C.1 plaintext; after done, a new start decrypts the new din correctly.
- rst_n pulsed low at cycle 13 of a block:
  - busy, done and dout drop to 0 asynchronously, and no done follows.
  - A subsequent C.1 start completes normally in 21 cycles.
- Back-to-back: start held high across two completions with App. B then C.1 vectors → two done pulses 22 cycles apart, each with the correct dout; dout stable between them.
